// File: rtl/pipeline_control.sv
// Stall/flush sequencer for the five-stage LEGv8 pipeline: load-use bubbles, branch
// redirects, data-memory wait freeze with timeout, post-reset clear and stall counting.
module pipeline_control #(
  parameter int INIT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      id_instr,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             mem_branch_taken,
  input  logic             mem_access,
  input  logic             mem_ack,
  output logic             pc_write,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             fault,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } state_t;

  localparam int ICNT_W = (INIT_CYCLES < 1) ? 1 : $clog2(INIT_CYCLES + 1);
  localparam int WCNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t              cur_state, nxt_state;
  logic [ICNT_W-1:0]   init_cnt;
  logic [WCNT_W-1:0]   wait_cnt;
  logic                fault_q;
  logic                use_rn, use_rm, use_rt;
  logic                load_use, mem_wait;
  logic [4:0]          rn, rm, rt;

  assign rn = id_instr[9:5];
  assign rm = id_instr[20:16];
  assign rt = id_instr[4:0];

  // Immediate/shamt fields never name a source register.
  logic unused_imm;
  assign unused_imm = &{1'b0, id_instr[15:10]};

  // ID-stage source-register decode
  always_comb begin
    use_rn = 1'b0;
    use_rm = 1'b0;
    use_rt = 1'b0;
    case (id_instr[31:21])
      OP_ADD, OP_SUB, OP_AND, OP_ORR: begin use_rn = 1'b1; use_rm = 1'b1; end
      OP_LDUR:                        use_rn = 1'b1;
      OP_STUR:                        begin use_rn = 1'b1; use_rt = 1'b1; end
      OP_CBZ:                         use_rt = 1'b1;
      default:                        ;
    endcase
  end

  assign load_use = ex_mem_read && (ex_rd != 5'd31) &&
                    ((use_rn && ex_rd == rn) || (use_rm && ex_rd == rm) ||
                     (use_rt && ex_rd == rt));
  assign mem_wait = mem_access && !mem_ack;

  // Next-state and enable/flush decode
  always_comb begin
    nxt_state    = cur_state;
    pc_write     = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    case (cur_state)
      INIT: begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        if (init_cnt >= ICNT_W'(INIT_CYCLES - 1)) nxt_state = RUN;
      end
      RUN, MEM_WAIT: begin
        if (mem_wait) begin
          if (cur_state == RUN)
            nxt_state = (MEM_TIMEOUT <= 1) ? ERROR : MEM_WAIT;
          else if (wait_cnt >= WCNT_W'(MEM_TIMEOUT - 1))
            nxt_state = ERROR;
        end else begin
          nxt_state = RUN;
          if (mem_branch_taken) begin
            // A load_use here belongs to the wrong path and is dropped.
            pc_write     = 1'b1;
            if_id_en     = 1'b1;
            id_ex_en     = 1'b1;
            ex_mem_en    = 1'b1;
            mem_wb_en    = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
          end else if (load_use) begin
            id_ex_en    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_en   = 1'b1;
            mem_wb_en   = 1'b1;
          end else begin
            pc_write  = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state    <= INIT;
      init_cnt     <= '0;
      wait_cnt     <= '0;
      stall_cycles <= '0;
      fault_q      <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (cur_state == INIT) init_cnt <= init_cnt + ICNT_W'(1);
      if (cur_state == RUN || cur_state == MEM_WAIT) begin
        if (!mem_wait)              wait_cnt <= '0;
        else if (cur_state == RUN)  wait_cnt <= WCNT_W'(1);
        else                        wait_cnt <= wait_cnt + WCNT_W'(1);
        if (!pc_write) stall_cycles <= sat_inc(stall_cycles);
      end
      if (nxt_state == ERROR) fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;
  assign state = cur_state;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control: expected control vectors are queued as each
// step is driven and popped/compared when the outputs are sampled mid-cycle.
module tb_pipeline_control;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      id_instr;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             mem_branch_taken;
  logic             mem_access;
  logic             mem_ack;
  logic             pc_write, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic             if_id_flush, id_ex_flush, ex_mem_flush, fault;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cycles;

  pipeline_control #(.INIT_CYCLES(4), .MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_instr(id_instr), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .mem_branch_taken(mem_branch_taken), .mem_access(mem_access),
    .mem_ack(mem_ack), .pc_write(pc_write), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .fault(fault),
    .state(state), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // {pc_write, if_id/id_ex/ex_mem/mem_wb en, if_id/id_ex/ex_mem flush, fault, state}
  localparam logic [10:0] V_INIT     = 11'b0_0000_111_0_00;
  localparam logic [10:0] V_NORMAL   = 11'b1_1111_000_0_01;
  localparam logic [10:0] V_BUBBLE   = 11'b0_0111_010_0_01;
  localparam logic [10:0] V_REDIRECT = 11'b1_1111_111_0_01;
  localparam logic [10:0] V_FRZ_RUN  = 11'b0_0000_000_0_01;
  localparam logic [10:0] V_FRZ_WAIT = 11'b0_0000_000_0_10;
  localparam logic [10:0] V_ACK_WAIT = 11'b1_1111_000_0_10;
  localparam logic [10:0] V_ERROR    = 11'b0_0000_000_1_11;

  localparam logic [31:0] I_ADD_X3   = 32'h8B040065;  // ADD X5,X3,X4
  localparam logic [31:0] I_ADD_X31  = 32'h8B0403E5;  // ADD X5,X31,X4
  localparam logic [31:0] I_CBZ      = 32'hB4000062;  // CBZ X2 (rn field=3)
  localparam logic [31:0] I_STUR     = 32'hF8000027;  // STUR X7,[X1]
  localparam logic [31:0] I_B        = 32'h14000003;  // B, low field = 3

  typedef struct {
    string            tag;
    logic [10:0]      vec;
    logic [CNT_W-1:0] stall;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic logic [10:0] observed();
    return {pc_write, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
            if_id_flush, id_ex_flush, ex_mem_flush, fault, state};
  endfunction

  // Queue the expectation, compare at the falling edge, then advance past the next rising edge.
  task automatic step(input string tag, input logic [10:0] vec, input int stall);
    exp_t e;
    logic [10:0] got;
    e.tag = tag; e.vec = vec; e.stall = CNT_W'(stall);
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    got = observed();
    n_vec++;
    assert (got === e.vec) else begin
      n_fail++;
      $error("FAIL %s ctrl: observed %b expected %b", e.tag, got, e.vec);
    end
    n_vec++;
    assert (stall_cycles === e.stall) else begin
      n_fail++;
      $error("FAIL %s stall_cycles: observed %0d expected %0d", e.tag, stall_cycles, e.stall);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; id_instr = 32'h0; ex_mem_read = 1'b0; ex_rd = 5'd0;
    mem_branch_taken = 1'b0; mem_access = 1'b0; mem_ack = 1'b0;
    #1;
    step("reset", V_INIT, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step("init", V_INIT, 0);
    step("run_idle", V_NORMAL, 0);

    ex_mem_read = 1'b1; ex_rd = 5'd3; id_instr = I_ADD_X3;
    step("load_use_add", V_BUBBLE, 0);
    ex_rd = 5'd31;
    step("rd31_add", V_NORMAL, 1);
    id_instr = I_ADD_X31;
    step("rd31_rn31", V_NORMAL, 1);

    id_instr = I_CBZ; ex_rd = 5'd3;
    step("cbz_rn_ignored", V_NORMAL, 1);
    ex_rd = 5'd2;
    step("cbz_rt_dep", V_BUBBLE, 1);
    id_instr = I_STUR; ex_rd = 5'd7;
    step("stur_rt_dep", V_BUBBLE, 2);
    id_instr = I_B; ex_rd = 5'd3;
    step("b_no_src", V_NORMAL, 3);

    id_instr = I_ADD_X3; ex_rd = 5'd3; mem_branch_taken = 1'b1;
    step("branch_over_lu", V_REDIRECT, 3);
    mem_branch_taken = 1'b0; ex_mem_read = 1'b0;
    step("after_branch", V_NORMAL, 3);

    mem_access = 1'b1; mem_ack = 1'b0; mem_branch_taken = 1'b1;
    step("wait1_over_br", V_FRZ_RUN, 3);
    mem_branch_taken = 1'b0;
    step("wait2", V_FRZ_WAIT, 4);
    step("wait3", V_FRZ_WAIT, 5);
    mem_ack = 1'b1;
    step("wait_ack", V_ACK_WAIT, 6);
    mem_access = 1'b0; mem_ack = 1'b0;
    step("resume", V_NORMAL, 6);

    mem_access = 1'b1;
    step("to_wait1", V_FRZ_RUN, 6);
    for (int i = 2; i <= 16; i++) step("to_wait", V_FRZ_WAIT, 5 + i);
    step("error", V_ERROR, 22);
    mem_ack = 1'b1; mem_access = 1'b0;
    step("error_sticky", V_ERROR, 22);

    #2 reset = 1'b1;
    #1;
    step("reset_mid", V_INIT, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
